// File: rtl/seq_shift_if.sv
// Handshake/operand bundle between a requester and the sequential shift unit.
// The requester drives the operands and start; the unit returns the result and status.
interface seq_shift_if #(
  parameter int WIDTH   = 12,
  parameter int SHAMT_W = 4
);
  logic               start;
  logic [1:0]         mode;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   in_data;
  logic [WIDTH-1:0]   out_data;
  logic               carry_out;
  logic               busy;
  logic               done;

  modport master (
    output start, mode, shamt, in_data,
    input  out_data, carry_out, busy, done
  );

  modport slave (
    input  start, mode, shamt, in_data,
    output out_data, carry_out, busy, done
  );
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: LSL, LSR, ASR or ROL by a variable amount,
// one bit position per clock, with a start/busy/done handshake.
module seq_shift_unit #(
  parameter int WIDTH   = 12,
  parameter int SHAMT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_shift_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   work;
  logic               carry;
  logic [1:0]         mode_q;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH:0]     step;

  // One 1-bit step; MSB of the result is the bit shifted (or wrapped) out.
  function automatic logic [WIDTH:0] shift_step(input logic [1:0] op,
                                                input logic [WIDTH-1:0] val);
    logic signed [WIDTH-1:0] sval;
    logic        [WIDTH:0]   res;
    sval = val;
    res  = '0;
    case (op)
      OP_LSL:  res = {val[WIDTH-1], val[WIDTH-2:0], 1'b0};
      OP_LSR:  res = {val[0], 1'b0, val[WIDTH-1:1]};
      OP_ASR:  res = {val[0], sval >>> 1};
      OP_ROL:  res = {val[WIDTH-1], val[WIDTH-2:0], val[WIDTH-1]};
      default: res = {1'b0, val};
    endcase
    return res;
  endfunction

  assign step = shift_step(mode_q, work);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (cnt == SHAMT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      carry  <= 1'b0;
      mode_q <= OP_LSL;
      cnt    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.start) begin
            work   <= bus.in_data;
            carry  <= 1'b0;
            mode_q <= bus.mode;
            cnt    <= bus.shamt;
          end
        end
        SHIFT: begin
          carry <= step[WIDTH];
          work  <= step[WIDTH-1:0];
          cnt   <= cnt - SHAMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Status is decoded straight from the state register, so busy and done are exclusive.
  assign bus.out_data  = work;
  assign bus.carry_out = carry;
  assign bus.busy      = (state == SHIFT);
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit at WIDTH=12, SHAMT_W=4 with hand-computed results.
module tb_seq_shift_unit;
  localparam int W  = 12;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seq_shift_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

  seq_shift_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start one operation and follow it to completion, checking latency, busy length and result.
  task automatic run_op(input string tag, input logic [1:0] m, input int k,
                        input logic [W-1:0] d, input logic [W-1:0] exp_out, input logic exp_c);
    int n;
    int busy_n;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.mode    = m;
    bus.shamt   = k[SW-1:0];
    bus.in_data = d;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.in_data = ~d;
    bus.mode    = ~m;
    bus.shamt   = ~k[SW-1:0];
    n = 1;
    busy_n = 0;
    while (!bus.done && n < 64) begin
      if (bus.busy) busy_n++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".latency"}, n, k + 1);
    check({tag, ".busy_cycles"}, busy_n, k);
    check({tag, ".busy_at_done"}, bus.busy, 1'b0);
    check({tag, ".out"}, bus.out_data, exp_out);
    check({tag, ".carry"}, bus.carry_out, exp_c);
    @(posedge clk); #1;
    check({tag, ".done_width"}, bus.done, 1'b0);
    check({tag, ".out_hold"}, bus.out_data, exp_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dones;
    logic [W-1:0] res;
    logic         res_c;
    bus.start   = 1'b0;
    bus.mode    = 2'b00;
    bus.shamt   = '0;
    bus.in_data = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset.out", bus.out_data, '0);
    check("reset.carry", bus.carry_out, 1'b0);
    check("reset.busy", bus.busy, 1'b0);
    check("reset.done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("lsl1",     2'b00, 1,  12'hF0C, 12'hE18, 1'b1);
    run_op("lsr3",     2'b01, 3,  12'hAC2, 12'h158, 1'b0);
    run_op("asr4",     2'b10, 4,  12'h801, 12'hF80, 1'b0);
    run_op("rol13",    2'b11, 13, 12'h800, 12'h001, 1'b1);
    run_op("shamt0",   2'b00, 0,  12'hAAA, 12'hAAA, 1'b0);
    run_op("asr15",    2'b10, 15, 12'h800, 12'hFFF, 1'b1);
    run_op("lsr15",    2'b01, 15, 12'hFFF, 12'h000, 1'b0);

    // A second start pulsed mid-operation must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'b00; bus.shamt = 4'd5; bus.in_data = 12'h0BF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'b11; bus.shamt = 4'd1; bus.in_data = 12'hFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0;
    res   = '0;
    res_c = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        dones++;
        res   = bus.out_data;
        res_c = bus.carry_out;
      end
      @(posedge clk); #1;
    end
    check("ignore.done_count", dones, 1);
    check("ignore.out", res, 12'h7E0);
    check("ignore.carry", res_c, 1'b1);

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'b00; bus.shamt = 4'd8; bus.in_data = 12'h0FF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst.busy_before", bus.busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.out", bus.out_data, '0);
    check("midrst.carry", bus.carry_out, 1'b0);
    check("midrst.busy", bus.busy, 1'b0);
    check("midrst.done", bus.done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("postrst.busy", bus.busy, 1'b0);
    check("postrst.done", bus.done, 1'b0);
    check("postrst.out", bus.out_data, '0);
    run_op("postrst_lsl2", 2'b00, 2, 12'h003, 12'h00C, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
